// File: rtl/data_mem_responder_if.sv
//==============================================================================
// Module   : data_mem_responder_if
// Brief    : CPU data-port and TX stream bundle for data_mem_responder.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] dataAddr;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  memWrite;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [7:0]            led;
    logic [7:0]            txData;
    logic                  txValid;
    logic                  txReady;

    modport slave (
        input  dataAddr, dataOut, memWrite, txReady,
        output dataIn, led, txData, txValid
    );

    modport master (
        output dataAddr, dataOut, memWrite, txReady,
        input  dataIn, led, txData, txValid
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
//==============================================================================
// Module   : data_mem_responder
// Brief    : Data RAM plus I/O page (LED, cycle counter, TX FIFO, status).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  RAM_WORDS  = 256,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE  = 32'h8000_0000,
    parameter int                  FIFO_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    data_mem_responder_if.slave   bus
);
    localparam int C_RAM_AW  = $clog2(RAM_WORDS);
    localparam int C_FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [RAM_WORDS];
    logic [7:0]            r_fifo [FIFO_DEPTH];
    logic [7:0]            r_led;
    logic [31:0]           r_cnt;
    logic [C_FIFO_AW-1:0]  r_wr_ptr;
    logic [C_FIFO_AW-1:0]  r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic                  r_ovf;

    logic                  w_sel_ram;
    logic                  w_sel_io;
    logic [1:0]            w_io_off;
    logic [C_RAM_AW-1:0]   w_ram_idx;
    logic                  w_ram_we;
    logic                  w_led_we;
    logic                  w_cnt_we;
    logic                  w_push_req;
    logic                  w_stat_we;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_stat;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    // Byte-offset bits of the address never affect word decode.
    assign w_unused  = ^bus.dataAddr[1:0];

    assign w_sel_ram = (bus.dataAddr[ADDR_WIDTH-1:C_RAM_AW+2] == '0);
    assign w_sel_io  = (bus.dataAddr[ADDR_WIDTH-1:4] == IO_BASE[ADDR_WIDTH-1:4]);
    assign w_io_off  = bus.dataAddr[3:2];
    assign w_ram_idx = bus.dataAddr[C_RAM_AW+1:2];

    assign w_ram_we   = bus.memWrite && w_sel_ram;
    assign w_led_we   = bus.memWrite && w_sel_io && (w_io_off == 2'd0);
    assign w_cnt_we   = bus.memWrite && w_sel_io && (w_io_off == 2'd1);
    assign w_push_req = bus.memWrite && w_sel_io && (w_io_off == 2'd2);
    assign w_stat_we  = bus.memWrite && w_sel_io && (w_io_off == 2'd3);

    assign w_full  = (r_count == C_CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.txReady;
    // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= bus.dataOut;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.dataOut[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led    <= '0;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_led_we) begin
                r_led <= bus.dataOut[7:0];
            end
            r_cnt <= w_cnt_we ? 32'd0 : r_cnt + 32'd1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_FIFO_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_W'(1);
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_stat_we && bus.dataOut[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_stat              = '0;
        w_stat[0]           = w_full;
        w_stat[1]           = w_empty;
        w_stat[2]           = r_ovf;
        w_stat[4 +: C_CNT_W] = r_count;
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_sel_io) begin
            case (w_io_off)
                2'd0:    w_rdata = DATA_WIDTH'(r_led);
                2'd1:    w_rdata = DATA_WIDTH'(r_cnt);
                2'd3:    w_rdata = w_stat;
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.dataIn  = w_rdata;
    assign bus.led     = r_led;
    assign bus.txValid = !w_empty;
    // Storage is not reset, so the head is masked while empty to keep txData at 0.
    assign bus.txData  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//==============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed bench with a queue/array reference model for data_mem_responder.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_data_mem_responder;
    localparam logic [31:0] C_IO   = 32'h8000_0000;
    localparam logic [31:0] C_LED  = C_IO + 32'h0;
    localparam logic [31:0] C_CNT  = C_IO + 32'h4;
    localparam logic [31:0] C_TXD  = C_IO + 32'h8;
    localparam logic [31:0] C_STAT = C_IO + 32'hC;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    data_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_WORDS(256),
        .IO_BASE(32'h8000_0000), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [256];
    bit          m_known [256];
    logic [7:0]  m_q [$];
    logic [7:0]  m_led;
    logic [31:0] m_cnt;
    bit          m_ovf;
    logic [31:0] m_a;
    bit          m_pop;
    logic [31:0] m_exp;
    bit          m_kn;
    logic [7:0]  drained [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] addr, output bit known);
        logic [31:0] a;
        int          n;
        a     = addr & 32'hFFFF_FFFC;
        known = 1'b1;
        n     = m_q.size();
        if (a < 32'd1024) begin
            known = m_known[a[9:2]];
            return m_ram[a[9:2]];
        end
        if (a == C_LED)  return {24'b0, m_led};
        if (a == C_CNT)  return m_cnt;
        if (a == C_STAT) return 32'(n == 4) + 32'((n == 0) ? 2 : 0) + 32'(m_ovf ? 4 : 0) + 32'(n * 16);
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_led = 8'h00;
            m_cnt = 32'h0;
            m_ovf = 1'b0;
        end else begin
            m_a   = bus.dataAddr & 32'hFFFF_FFFC;
            m_pop = (m_q.size() != 0) && bus.txReady;
            if (m_pop) m_q.delete(0);
            if (bus.memWrite && m_a == C_TXD) begin
                if (m_q.size() < 4) m_q.push_back(bus.dataOut[7:0]);
                else m_ovf = 1'b1;
            end
            if (bus.memWrite && m_a == C_STAT && bus.dataOut[2]) m_ovf = 1'b0;
            m_cnt = (bus.memWrite && m_a == C_CNT) ? 32'h0 : m_cnt + 32'h1;
            if (bus.memWrite && m_a == C_LED) m_led = bus.dataOut[7:0];
            if (bus.memWrite && m_a < 32'd1024) begin
                m_ram[m_a[9:2]]   = bus.dataOut;
                m_known[m_a[9:2]] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && chk_en) begin
            m_exp = exp_read(bus.dataAddr, m_kn);
            if (m_kn) chk("model_dataIn", bus.dataIn, m_exp);
            chk("model_led", {24'b0, bus.led}, {24'b0, m_led});
            chk("model_txValid", {31'b0, bus.txValid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) chk("model_txData", {24'b0, bus.txData}, {24'b0, m_q[0]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic wr);
        bus.dataAddr = addr;
        bus.dataOut  = data;
        bus.memWrite = wr;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        rst = 1'b0;
        bus.txReady = 1'b0;
        drive(C_CNT, 32'h0, 1'b0);
        #3;
        chk("rst_txValid", {31'b0, bus.txValid}, 32'h0);
        chk("rst_led", {24'b0, bus.led}, 32'h0);
        chk("rst_txData", {24'b0, bus.txData}, 32'h0);
        chk("rst_cnt", bus.dataIn, 32'h0);
        #10;
        rst = 1'b1;
        chk_en = 1'b1;
        cyc();

        // RAM write, same-cycle read returns old data
        drive(32'h10, 32'h1111_1111, 1'b1);
        cyc();
        drive(32'h10, 32'hDEAD_BEEF, 1'b1);
        #1 chk("ram_same_cycle_old", bus.dataIn, 32'h1111_1111);
        cyc();
        drive(32'h13, 32'h0, 1'b0);
        #1 chk("ram_read_new", bus.dataIn, 32'hDEAD_BEEF);
        cyc();

        // Unmapped read and ignored write
        drive(32'h4000_0000, 32'h0, 1'b0);
        #1 chk("unmapped_read", bus.dataIn, 32'h0);
        cyc();
        drive(32'h4000_0000, 32'hFFFF_FFFF, 1'b1);
        cyc();
        drive(32'h10, 32'h0, 1'b0);
        #1 chk("unmapped_ram", bus.dataIn, 32'hDEAD_BEEF);
        chk("unmapped_led", {24'b0, bus.led}, 32'h0);
        cyc();
        drive(C_STAT, 32'h0, 1'b0);
        #1 chk("unmapped_stat", bus.dataIn, 32'h2);
        cyc();

        // LED
        drive(C_LED, 32'h1234_56A5, 1'b1);
        cyc();
        drive(C_LED, 32'h0, 1'b0);
        #1 chk("led_read", bus.dataIn, 32'h0000_00A5);
        cyc();

        // Counter: wrap and clear
        drive(C_CNT, 32'h0, 1'b0);
        force dut.r_cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_cnt;
        chk("cnt_preload", bus.dataIn, 32'hFFFF_FFFE);
        cyc();
        chk("cnt_max", bus.dataIn, 32'hFFFF_FFFF);
        cyc();
        chk("cnt_wrap", bus.dataIn, 32'h0);
        cyc();
        cyc();
        drive(C_CNT, 32'h5555_5555, 1'b1);
        cyc();
        drive(C_CNT, 32'h0, 1'b0);
        #1 chk("cnt_clear", bus.dataIn, 32'h0);
        cyc();

        // FIFO overflow with consumer stalled
        for (int i = 0; i < 5; i++) begin
            drive(C_TXD, 32'h41 + i, 1'b1);
            cyc();
        end
        drive(C_STAT, 32'h0, 1'b0);
        #1 chk("stat_full_ovf", bus.dataIn, 32'h45);
        chk("head_41", {24'b0, bus.txData}, 32'h41);
        cyc();
        drive(C_STAT, 32'h4, 1'b1);
        cyc();
        drive(C_STAT, 32'h0, 1'b0);
        #1 chk("stat_ovf_clr", bus.dataIn, 32'h41);
        cyc();

        // Push into full FIFO while popping
        drive(C_TXD, 32'h46, 1'b1);
        bus.txReady = 1'b1;
        cyc();
        bus.txReady = 1'b0;
        drive(C_STAT, 32'h0, 1'b0);
        #1 chk("stat_push_pop_full", bus.dataIn, 32'h41);
        chk("head_42", {24'b0, bus.txData}, 32'h42);
        cyc();
        bus.txReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.txValid) drained.push_back(bus.txData);
            cyc();
        end
        bus.txReady = 1'b0;
        chk("drain_count", drained.size(), 32'd4);
        if (drained.size() == 4) chk("drain_last", {24'b0, drained[3]}, 32'h46);

        // Reset mid-drain
        drive(C_TXD, 32'h60, 1'b1);
        cyc();
        drive(C_TXD, 32'h61, 1'b1);
        cyc();
        drive(C_LED, 32'h3C, 1'b1);
        bus.txReady = 1'b1;
        cyc();
        drive(C_CNT, 32'h0, 1'b0);
        #1 chk("pre_rst_txValid", {31'b0, bus.txValid}, 32'h1);
        rst = 1'b0;
        #1 chk("mid_rst_txValid", {31'b0, bus.txValid}, 32'h0);
        chk("mid_rst_led", {24'b0, bus.led}, 32'h0);
        chk("mid_rst_cnt", bus.dataIn, 32'h0);
        chk("mid_rst_txData", {24'b0, bus.txData}, 32'h0);
        drive(C_STAT, 32'h0, 1'b0);
        #1 chk("mid_rst_stat", bus.dataIn, 32'h2);
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
